// File: rtl/regwrite_arbiter.sv
// Two-requester register-file writeback arbiter: per-requester FIFOs, round-robin issue on ties,
// registered write port and combinational pending-write (busy) lookup. Option macro: REGARB_XZR_DROP_EN.
module regwrite_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              regwrite,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readAddress1,
    input  logic [ADDR_W-1:0] readAddress2,
    output logic              busy1,
    output logic              busy2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
`ifdef REGARB_XZR_DROP_EN
    localparam logic [ADDR_W-1:0] XZR_ADDR = ADDR_W'(31);
`endif

    typedef enum logic {
        GNT_EX = 1'b0,
        GNT_LD = 1'b1
    } grant_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_IDX) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Slot idx holds a live entry when its distance from the read pointer is below the count.
    function automatic logic entry_live(input logic [PW-1:0] idx,
                                        input logic [PW-1:0] rd,
                                        input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = idx - rd;
        return ({1'b0, off} < cnt);
    endfunction

    logic [ADDR_W-1:0] ex_addr_mem_q [DEPTH];
    logic [DATA_W-1:0] ex_data_mem_q [DEPTH];
    logic [ADDR_W-1:0] ld_addr_mem_q [DEPTH];
    logic [DATA_W-1:0] ld_data_mem_q [DEPTH];

    logic [PW-1:0] ex_wp_q, ex_wp_d, ex_rp_q, ex_rp_d;
    logic [PW-1:0] ld_wp_q, ld_wp_d, ld_rp_q, ld_rp_d;
    logic [CW-1:0] ex_cnt_q, ex_cnt_d, ld_cnt_q, ld_cnt_d;
    grant_e        last_q, last_d;

    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic ex_push_s, ld_push_s, ex_store_s, ld_store_s;
    logic ex_head_v_s, ld_head_v_s, gnt_ex_s, gnt_ld_s;
    logic [DEPTH-1:0] ex_live_s, ld_live_s;
    logic busy1_s, busy2_s;

    assign ex_ready  = (ex_cnt_q < DEPTH_C);
    assign ld_ready  = (ld_cnt_q < DEPTH_C);
    assign ex_push_s = ex_valid & ex_ready;
    assign ld_push_s = ld_valid & ld_ready;

    // Writes to the zero register are handshaken normally but never stored, so they cannot
    // issue, flag busy or take part in arbitration.
`ifdef REGARB_XZR_DROP_EN
    assign ex_store_s = ex_push_s & (ex_addr != XZR_ADDR);
    assign ld_store_s = ld_push_s & (ld_addr != XZR_ADDR);
`else
    assign ex_store_s = ex_push_s;
    assign ld_store_s = ld_push_s;
`endif

    assign ex_head_v_s = (ex_cnt_q != {CW{1'b0}});
    assign ld_head_v_s = (ld_cnt_q != {CW{1'b0}});

    // Round-robin grant; the fairness pointer moves only when both heads compete.
    always_comb begin
        gnt_ex_s = 1'b0;
        gnt_ld_s = 1'b0;
        last_d   = last_q;
        if (ex_head_v_s && ld_head_v_s) begin
            if (last_q == GNT_LD) begin
                gnt_ex_s = 1'b1;
                last_d   = GNT_EX;
            end else begin
                gnt_ld_s = 1'b1;
                last_d   = GNT_LD;
            end
        end else if (ex_head_v_s) begin
            gnt_ex_s = 1'b1;
        end else if (ld_head_v_s) begin
            gnt_ld_s = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // Queue pointer and occupancy next-state.
    always_comb begin
        ex_wp_d  = ex_store_s ? ptr_inc(ex_wp_q) : ex_wp_q;
        ex_rp_d  = gnt_ex_s   ? ptr_inc(ex_rp_q) : ex_rp_q;
        ld_wp_d  = ld_store_s ? ptr_inc(ld_wp_q) : ld_wp_q;
        ld_rp_d  = gnt_ld_s   ? ptr_inc(ld_rp_q) : ld_rp_q;
        ex_cnt_d = ex_cnt_q + CW'(ex_store_s) - CW'(gnt_ex_s);
        ld_cnt_d = ld_cnt_q + CW'(ld_store_s) - CW'(gnt_ld_s);
    end

    // Write-port next-state; address/data hold when nothing issues.
    always_comb begin
        regwrite_d = gnt_ex_s | gnt_ld_s;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (gnt_ex_s) begin
            waddr_d = ex_addr_mem_q[ex_rp_q];
            wdata_d = ex_data_mem_q[ex_rp_q];
        end else if (gnt_ld_s) begin
            waddr_d = ld_addr_mem_q[ld_rp_q];
            wdata_d = ld_data_mem_q[ld_rp_q];
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_wp_q    <= {PW{1'b0}};
            ex_rp_q    <= {PW{1'b0}};
            ld_wp_q    <= {PW{1'b0}};
            ld_rp_q    <= {PW{1'b0}};
            ex_cnt_q   <= {CW{1'b0}};
            ld_cnt_q   <= {CW{1'b0}};
            last_q     <= GNT_LD;
            regwrite_q <= 1'b0;
            waddr_q    <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
        end else begin
            ex_wp_q    <= ex_wp_d;
            ex_rp_q    <= ex_rp_d;
            ld_wp_q    <= ld_wp_d;
            ld_rp_q    <= ld_rp_d;
            ex_cnt_q   <= ex_cnt_d;
            ld_cnt_q   <= ld_cnt_d;
            last_q     <= last_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Queue entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ex_addr_mem_q[i] <= {ADDR_W{1'b0}};
                ex_data_mem_q[i] <= {DATA_W{1'b0}};
                ld_addr_mem_q[i] <= {ADDR_W{1'b0}};
                ld_data_mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (ex_store_s) begin
                ex_addr_mem_q[ex_wp_q] <= ex_addr;
                ex_data_mem_q[ex_wp_q] <= ex_data;
            end else begin
                ex_addr_mem_q[ex_wp_q] <= ex_addr_mem_q[ex_wp_q];
                ex_data_mem_q[ex_wp_q] <= ex_data_mem_q[ex_wp_q];
            end
            if (ld_store_s) begin
                ld_addr_mem_q[ld_wp_q] <= ld_addr;
                ld_data_mem_q[ld_wp_q] <= ld_data;
            end else begin
                ld_addr_mem_q[ld_wp_q] <= ld_addr_mem_q[ld_wp_q];
                ld_data_mem_q[ld_wp_q] <= ld_data_mem_q[ld_wp_q];
            end
        end
    end

    // Live-slot masks for both queues.
    always_comb begin
        ex_live_s = {DEPTH{1'b0}};
        ld_live_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            ex_live_s[i] = entry_live(PW'(i), ex_rp_q, ex_cnt_q);
            ld_live_s[i] = entry_live(PW'(i), ld_rp_q, ld_cnt_q);
        end
    end

    // Pending-write lookup across queued entries and the write port.
    always_comb begin
        busy1_s = regwrite_q & (waddr_q == readAddress1);
        busy2_s = regwrite_q & (waddr_q == readAddress2);
        for (int i = 0; i < DEPTH; i++) begin
            busy1_s = busy1_s
                    | (ex_live_s[i] & (ex_addr_mem_q[i] == readAddress1))
                    | (ld_live_s[i] & (ld_addr_mem_q[i] == readAddress1));
            busy2_s = busy2_s
                    | (ex_live_s[i] & (ex_addr_mem_q[i] == readAddress2))
                    | (ld_live_s[i] & (ld_addr_mem_q[i] == readAddress2));
        end
    end

    assign regwrite     = regwrite_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign busy1        = busy1_s;
    assign busy2        = busy2_s;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed vector table, a mid-operation reset
// sequence, then random traffic against a queue-based reference model.
module tb_regwrite_arbiter;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
`ifdef REGARB_XZR_DROP_EN
    localparam bit XZR_DROP = 1'b1;
`else
    localparam bit XZR_DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic ex_valid, ex_ready, ld_valid, ld_ready;
    logic [AW-1:0] ex_addr, ld_addr, writeAddress, readAddress1, readAddress2;
    logic [DW-1:0] ex_data, ld_data, writeData;
    logic regwrite, busy1, busy2;

    always #5 clk = ~clk;

    regwrite_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .regwrite(regwrite), .writeAddress(writeAddress), .writeData(writeData),
        .readAddress1(readAddress1), .readAddress2(readAddress2),
        .busy1(busy1), .busy2(busy2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_addr = '0; ex_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            exv;
        logic [AW-1:0] exa;
        logic [DW-1:0] exd;
        bit            ldv;
        logic [AW-1:0] lda;
        logic [DW-1:0] ldd;
        logic [AW-1:0] ra1, ra2;
        bit xr, lr, rw;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit b1, b2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int exv, input int exa, input int exd,
                                input int ldv, input int lda, input int ldd,
                                input int ra1, input int ra2,
                                input int xr, input int lr, input int rw,
                                input int wa, input int wd, input int b1, input int b2);
        vec_t v;
        v.exv = exv[0]; v.exa = AW'(exa); v.exd = DW'(exd);
        v.ldv = ldv[0]; v.lda = AW'(lda); v.ldd = DW'(ldd);
        v.ra1 = AW'(ra1); v.ra2 = AW'(ra2);
        v.xr = xr[0]; v.lr = lr[0]; v.rw = rw[0];
        v.wa = AW'(wa); v.wd = DW'(wd); v.b1 = b1[0]; v.b2 = b2[0];
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exq[$];
    ent_t ldq[$];
    bit            m_last_ld = 1'b1;
    bit            m_rw = 1'b0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;

    function automatic bit m_busy(input logic [AW-1:0] ra);
        if (m_rw && m_wa == ra) return 1'b1;
        foreach (exq[i]) if (exq[i].a == ra) return 1'b1;
        foreach (ldq[i]) if (ldq[i].a == ra) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit   ex_acc, ld_acc;
        int   pick;
        ent_t e;
        ex_acc = ex_valid && (exq.size() < DEPTH);
        ld_acc = ld_valid && (ldq.size() < DEPTH);
        pick = 0;
        if (exq.size() > 0 && ldq.size() > 0) begin
            pick = m_last_ld ? 1 : 2;
            m_last_ld = (pick == 2);
        end else if (exq.size() > 0) begin
            pick = 1;
        end else if (ldq.size() > 0) begin
            pick = 2;
        end
        m_rw = (pick != 0);
        if (pick == 1) begin
            e = exq.pop_front(); m_wa = e.a; m_wd = e.d;
        end else if (pick == 2) begin
            e = ldq.pop_front(); m_wa = e.a; m_wd = e.d;
        end
        if (ex_acc && !(XZR_DROP && ex_addr == AW'(31))) exq.push_back({ex_addr, ex_data});
        if (ld_acc && !(XZR_DROP && ld_addr == AW'(31))) ldq.push_back({ld_addr, ld_data});
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d ex_ready", cyc), ex_ready, (exq.size() < DEPTH));
        chk($sformatf("rnd%0d ld_ready", cyc), ld_ready, (ldq.size() < DEPTH));
        chk($sformatf("rnd%0d regwrite", cyc), regwrite, m_rw);
        if (m_rw) begin
            chk($sformatf("rnd%0d writeAddress", cyc), writeAddress, m_wa);
            chk($sformatf("rnd%0d writeData", cyc), writeData, m_wd);
        end
        chk($sformatf("rnd%0d busy1", cyc), busy1, m_busy(readAddress1));
        chk($sformatf("rnd%0d busy2", cyc), busy2, m_busy(readAddress2));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return AW'(31);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        int nx;
        nx = XZR_DROP ? 0 : 1;
        //         exv exa exd   ldv lda ldd   ra1 ra2  xr lr rw wa  wd    b1 b2
        tbl.push_back(mk(1, 3, 'h11, 0, 0, 0,    3, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    3, 0,  1, 1, 0, 0,  0,    1, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    3, 0,  1, 1, 1, 3,  'h11, 1, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    3, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(1, 1, 'hA1, 1, 2, 'hB1, 0, 5,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(1, 4, 'hA2, 1, 5, 'hB2, 0, 5,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 5,  1, 0, 1, 1,  'hA1, 0, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 5,  1, 1, 1, 2,  'hB1, 0, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 5,  1, 1, 1, 4,  'hA2, 0, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 5,  1, 1, 1, 5,  'hB2, 0, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 5,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(1, 8, 'hC1, 1, 9, 'hD1, 0, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(1, 10,'hC2, 1, 11,'hD2, 0, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(1, 12,'hC3, 0, 0, 0,    0, 0,  0, 1, 1, 9,  'hD1, 0, 0));
        tbl.push_back(mk(1, 12,'hC3, 0, 0, 0,    0, 0,  1, 1, 1, 8,  'hC1, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  0, 1, 1, 11, 'hD2, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  1, 1, 1, 10, 'hC2, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  1, 1, 1, 12, 'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(0, 0, 0,    1, 7, 'h77, 7, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    7, 0,  1, 1, 0, 0,  0,    1, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    7, 0,  1, 1, 1, 7,  'h77, 1, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    7, 0,  1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(1, 31,'h31, 0, 0, 0,    0, 31, 1, 1, 0, 0,  0,    0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 31, 1, 1, 0, 0,  0,    0, nx));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 31, 1, 1, nx,31, 'h31, 0, nx));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 31, 1, 1, 0, 0,  0,    0, 0));

        // reset state
        reset_n = 1'b0;
        idle();
        readAddress1 = '0;
        readAddress2 = '0;
        #1;
        chk("reset regwrite", regwrite, 1'b0);
        chk("reset writeAddress", writeAddress, '0);
        chk("reset writeData", writeData, '0);
        chk("reset ex_ready", ex_ready, 1'b1);
        chk("reset ld_ready", ld_ready, 1'b1);
        chk("reset busy1", busy1, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            ex_valid = tbl[i].exv; ex_addr = tbl[i].exa; ex_data = tbl[i].exd;
            ld_valid = tbl[i].ldv; ld_addr = tbl[i].lda; ld_data = tbl[i].ldd;
            readAddress1 = tbl[i].ra1; readAddress2 = tbl[i].ra2;
            #1;
            chk($sformatf("row%0d ex_ready", i), ex_ready, tbl[i].xr);
            chk($sformatf("row%0d ld_ready", i), ld_ready, tbl[i].lr);
            chk($sformatf("row%0d regwrite", i), regwrite, tbl[i].rw);
            if (tbl[i].rw) begin
                chk($sformatf("row%0d writeAddress", i), writeAddress, tbl[i].wa);
                chk($sformatf("row%0d writeData", i), writeData, tbl[i].wd);
            end
            chk($sformatf("row%0d busy1", i), busy1, tbl[i].b1);
            chk($sformatf("row%0d busy2", i), busy2, tbl[i].b2);
        end
        @(negedge clk);
        idle();

        // reset with three entries queued and a write in flight
        @(negedge clk);
        ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 64'h1;
        ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 64'h2;
        @(negedge clk);
        ex_addr = 5'd3; ex_data = 64'h3; ld_addr = 5'd4; ld_data = 64'h4;
        @(negedge clk);
        idle();
        readAddress1 = 5'd3;
        readAddress2 = 5'd4;
        #1;
        chk("midrst pre regwrite", regwrite, 1'b1);
        chk("midrst pre busy1", busy1, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst regwrite", regwrite, 1'b0);
        chk("midrst ex_ready", ex_ready, 1'b1);
        chk("midrst ld_ready", ld_ready, 1'b1);
        chk("midrst busy1", busy1, 1'b0);
        chk("midrst busy2", busy2, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release ex_ready", ex_ready, 1'b1);
        chk("release ld_ready", ld_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-release%0d regwrite", k), regwrite, 1'b0);
            chk($sformatf("post-release%0d busy1", k), busy1, 1'b0);
            chk($sformatf("post-release%0d busy2", k), busy2, 1'b0);
        end

        // random traffic against the model (DUT is empty with fairness at its reset value)
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            ex_valid = ($urandom_range(0, 99) < 60);
            ex_addr  = rand_addr();
            ex_data  = {$urandom, $urandom};
            ld_valid = ($urandom_range(0, 99) < 60);
            ld_addr  = rand_addr();
            ld_data  = {$urandom, $urandom};
            readAddress1 = rand_addr();
            readAddress2 = rand_addr();
            #1;
            check_model(c);
            @(posedge clk);
            model_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
